// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller:
// forward-select encodings, controller FSM states, register-zero constant and
// small helpers used by the forwarding and counter logic.
package pipe_ctrl_pkg;

    // Operand source selected by the EXE-stage forwarding muxes.
    typedef enum logic [1:0] {
        FROM_REG          = 2'd0,
        FROM_EXMEM_ALUOUT = 2'd1,
        FROM_MEMWB_ALUOUT = 2'd2,
        FROM_MEMWB_DM     = 2'd3
    } fwd_sel_e;

    // Controller states: reset bring-up, normal running, post-load-use cycle.
    typedef enum logic [1:0] {
        S_RST = 2'd0,
        S_RUN = 2'd1,
        S_LU  = 2'd2
    } ctrl_state_e;

    // $zero is hardwired; it never produces a real dependence.
    localparam logic [4:0] GPR_ZERO = 5'd0;

    // A source depends on a producer only if it is actually read, is not $zero,
    // and the producer writes that same register.
    function automatic logic src_match(
        input logic       used,
        input logic [4:0] src,
        input logic       wen,
        input logic [4:0] dst
    );
        return used && (src != GPR_ZERO) && wen && (dst == src);
    endfunction

    // Saturating increment for the event counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select_unit.sv
// Per-operand dependence detection and forward-source priority select.
// Reports which pipeline producers (EXE/MEM/WB) the operand depends on and
// picks the nearest one that can actually be forwarded into EXE.
module fwd_select_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       src_used,
    input  logic [4:0] src_addr,
    input  logic [4:0] exe_addr,
    input  logic       exe_wen,
    input  logic [4:0] mem_addr,
    input  logic       mem_wen,
    input  logic       mem_ren,
    input  logic [4:0] wb_addr,
    input  logic       wb_wen,
    output fwd_sel_e   sel,
    output logic       hit_exe,
    output logic       hit_mem,
    output logic       hit_wb
);

    assign hit_exe = src_match(src_used, src_addr, exe_wen, exe_addr);
    assign hit_mem = src_match(src_used, src_addr, mem_wen, mem_addr);
    assign hit_wb  = src_match(src_used, src_addr, wb_wen,  wb_addr);

    // Nearest producer wins: the EXE producer will sit in MEM next cycle, the
    // MEM producer will sit in WB (load data or ALU result).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sel = FROM_REG;
        if (hit_exe) begin
            sel = FROM_EXMEM_ALUOUT;
        end else if (hit_mem) begin
            sel = mem_ren ? FROM_MEMWB_DM : FROM_MEMWB_ALUOUT;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS datapath.
// Drives per-stage rst/en pairs (reset bring-up, load-use and branch-operand
// interlocks, wrong-path flush on a MEM-resolved jump/branch) and the
// registered EXE forward selects.
// Optional: define PIPE_PERF_CNT_EN to add saturating cycle/stall/flush counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYC = 2,
    parameter int FWD_W        = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_data_id,
    input  logic             rs_used_id,
    input  logic             rt_used_id,
    input  logic             is_branch_id,
    input  logic [4:0]       regw_addr_exe,
    input  logic             wb_wen_exe,
    input  logic             mem_ren_exe,
    input  logic [4:0]       regw_addr_mem,
    input  logic             wb_wen_mem,
    input  logic             mem_ren_mem,
    input  logic [4:0]       regw_addr_wb,
    input  logic             wb_wen_wb,
    input  logic             is_branch_mem,
    output logic             if_rst,
    output logic             if_en,
    output logic             id_rst,
    output logic             id_en,
    output logic             exe_rst,
    output logic             exe_en,
    output logic             mem_rst,
    output logic             mem_en,
    output logic             wb_rst,
    output logic             wb_en,
    output logic [FWD_W-1:0] exe_fwd_a_ctrl,
    output logic [FWD_W-1:0] exe_fwd_b_ctrl,
    output logic             stall_o
`ifdef PIPE_PERF_CNT_EN
    ,
    input  logic             perf_clr,
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stalls,
    output logic [31:0]      perf_flushes
`endif
);

    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD_CYC - 1);

    ctrl_state_e state, state_nxt;
    logic [3:0]  hold_cnt, hold_cnt_nxt;

    logic [4:0]  rs_addr, rt_addr;
    fwd_sel_e    sel_rs, sel_rt;
    logic        rs_hit_exe, rs_hit_mem, rs_hit_wb;
    logic        rt_hit_exe, rt_hit_mem, rt_hit_wb;
    logic        load_use, branch_hazard;
    logic [FWD_W-1:0] fwd_a_q, fwd_b_q;

    assign rs_addr = inst_data_id[25:21];
    assign rt_addr = inst_data_id[20:16];

    // Opcode/immediate fields are decoded elsewhere.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_data_id[31:26], inst_data_id[15:0]};

    fwd_select_unit u_fwd_rs (
        .src_used (rs_used_id),
        .src_addr (rs_addr),
        .exe_addr (regw_addr_exe),
        .exe_wen  (wb_wen_exe),
        .mem_addr (regw_addr_mem),
        .mem_wen  (wb_wen_mem),
        .mem_ren  (mem_ren_mem),
        .wb_addr  (regw_addr_wb),
        .wb_wen   (wb_wen_wb),
        .sel      (sel_rs),
        .hit_exe  (rs_hit_exe),
        .hit_mem  (rs_hit_mem),
        .hit_wb   (rs_hit_wb)
    );

    fwd_select_unit u_fwd_rt (
        .src_used (rt_used_id),
        .src_addr (rt_addr),
        .exe_addr (regw_addr_exe),
        .exe_wen  (wb_wen_exe),
        .mem_addr (regw_addr_mem),
        .mem_wen  (wb_wen_mem),
        .mem_ren  (mem_ren_mem),
        .wb_addr  (regw_addr_wb),
        .wb_wen   (wb_wen_wb),
        .sel      (sel_rt),
        .hit_exe  (rt_hit_exe),
        .hit_mem  (rt_hit_mem),
        .hit_wb   (rt_hit_wb)
    );

    // A load in EXE cannot forward its data until it reaches WB.
    assign load_use = mem_ren_exe && (rs_hit_exe || rt_hit_exe);

    // Branch compare and JR target read the register file directly, so any
    // in-flight producer of a used source must drain past WB first.
    assign branch_hazard = is_branch_id &&
                           (rs_hit_exe || rs_hit_mem || rs_hit_wb ||
                            rt_hit_exe || rt_hit_mem || rt_hit_wb);

    // State and bring-up counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RST;
            hold_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state and stage-control decode.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if_rst  = 1'b1;  if_en  = 1'b0;
        id_rst  = 1'b1;  id_en  = 1'b0;
        exe_rst = 1'b1;  exe_en = 1'b0;
        mem_rst = 1'b1;  mem_en = 1'b0;
        wb_rst  = 1'b1;  wb_en  = 1'b0;
        stall_o = 1'b0;

        unique case (state)
            S_RST: begin
                // Counter reaches RST_HOLD_CYC on the same edge that enters S_RUN.
                hold_cnt_nxt = hold_cnt + 4'd1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN, S_LU: begin
                if_rst  = 1'b0;  if_en  = 1'b1;
                id_rst  = 1'b0;  id_en  = 1'b1;
                exe_rst = 1'b0;  exe_en = 1'b1;
                mem_rst = 1'b0;  mem_en = 1'b1;
                wb_rst  = 1'b0;  wb_en  = 1'b1;
                state_nxt = S_RUN;

                if (is_branch_mem) begin
                    // Squash the three younger wrong-path instructions; the PC
                    // loads the target and the branch itself retires (JAL link).
                    id_rst  = 1'b1;
                    exe_rst = 1'b1;
                    mem_rst = 1'b1;
                end else if (load_use && (state == S_RUN)) begin
                    // One bubble: after it the load is in MEM and forwards from WB.
                    if_en     = 1'b0;
                    id_en     = 1'b0;
                    exe_rst   = 1'b1;
                    stall_o   = 1'b1;
                    state_nxt = S_LU;
                end else if (branch_hazard) begin
                    // Re-evaluated every cycle until the producer has left WB.
                    if_en   = 1'b0;
                    id_en   = 1'b0;
                    exe_rst = 1'b1;
                    stall_o = 1'b1;
                end
            end

            default: begin
                state_nxt = S_RST;
            end
        endcase
    end

    // Forward selects travel with the instruction into EXE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_W'(FROM_REG);
            fwd_b_q <= FWD_W'(FROM_REG);
        end else if (exe_rst) begin
            fwd_a_q <= FWD_W'(FROM_REG);
            fwd_b_q <= FWD_W'(FROM_REG);
        end else if (exe_en) begin
            fwd_a_q <= FWD_W'(sel_rs);
            fwd_b_q <= FWD_W'(sel_rt);
        end
    end

    assign exe_fwd_a_ctrl = fwd_a_q;
    assign exe_fwd_b_ctrl = fwd_b_q;

`ifdef PIPE_PERF_CNT_EN
    logic running;
    assign running = (state != S_RST);

    // Saturating event counters; clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles  <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else if (perf_clr) begin
            perf_cycles  <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else if (running) begin
            perf_cycles <= sat_inc(perf_cycles);
            if (stall_o) begin
                perf_stalls <= sat_inc(perf_stalls);
            end
            if (is_branch_mem) begin
                perf_flushes <= sat_inc(perf_flushes);
            end
        end
    end
`endif

endmodule
